cpu_dma_master: RTL and testbench

CPU_DMA_MASTER -- requirements
Module: cpu_dma_master

---
 rtl/cpu_dma_master.sv | 238 +++++++++++++++++++++++
 tb/tb_cpu_dma_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dma_master.sv
// rtl/cpu_dma_master.sv - DMA bus master: bus arbitration, longword and split 16-bit cycles, FIFO strobes
// All bus outputs are registered; each one changes on the edge that enters the state that owns it.
module cpu_dma_master #(
   parameter int BURST_LEN  = 4,
   parameter int LVL_W      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             SCLK,
   input  logic             _RST,
   input  logic             DMAENA,
   input  logic             DMADIR,
   input  logic [LVL_W-1:0] FIFO_LEVEL,
   input  logic             FLUSHFIFO,
   input  logic             BG_,
   input  logic             AS_IN_,
   input  logic             BGACK_IN_,
   input  logic             DSACK0_,
   input  logic             DSACK1_,
   input  logic             STERM_,
   input  logic             BERR_,
   output logic             BR_,
   output logic             BGACK_,
   output logic             AS_,
   output logic             DS_,
   output logic             RW,
   output logic [1:0]       SIZ,
   output logic             A1,
   output logic             FIFO_POP,
   output logic             FIFO_PUSH,
   output logic             INCADR,
   output logic             BUSERR,
   output logic [3:0]       STATE
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_REQ   = 4'd1,
      S_ARB   = 4'd2,
      S_START = 4'd3,
      S_WAIT  = 4'd4,
      S_TERM  = 4'd5,
      S_NEXT  = 4'd6,
      S_REL   = 4'd7,
      S_ERR   = 4'd8
   } state_t;

   localparam logic [LVL_W-1:0] LVL_BURST = LVL_W'(BURST_LEN);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] LVL_ROOM  = LVL_W'(FIFO_DEPTH - BURST_LEN);
   localparam logic [3:0]       CNT_MAX   = 4'(BURST_LEN);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       half_q, half_d;
   logic       br_q, br_d, bgack_q, bgack_d, as_q, as_d, ds_q, ds_d;
   logic       rw_q, rw_d, a1_q, a1_d;
   logic [1:0] siz_q, siz_d;
   logic       pop_q, pop_d, push_q, push_d, inc_q, inc_d;
   logic       buserr_q, buserr_d;

   logic start_ok, stop_burst, bus_fail, word_done, half_done;

   always_comb begin
      start_ok = 1'b0;
      if (DMAENA && !buserr_q) begin
         if (DMADIR)
            start_ok = (FIFO_LEVEL >= LVL_BURST) || (FLUSHFIFO && (FIFO_LEVEL != '0));
         else
            start_ok = (FIFO_LEVEL <= LVL_ROOM);
      end
   end

   // Termination priority: BERR_ over STERM_ over DSACK; a lone DSACK0_ means an 8-bit port.
   assign bus_fail  = !BERR_ || (STERM_ && !DSACK0_ && DSACK1_);
   assign word_done = !bus_fail && (!STERM_ || (!DSACK1_ && !DSACK0_) || (!DSACK1_ && DSACK0_ && a1_q));
   assign half_done = !bus_fail && STERM_ && !DSACK1_ && DSACK0_ && !a1_q;

   assign stop_burst = (cnt_q == CNT_MAX) || !DMAENA ||
                       (DMADIR && (FIFO_LEVEL == '0)) ||
                       (!DMADIR && (FIFO_LEVEL == LVL_FULL));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      br_d     = br_q;
      bgack_d  = bgack_q;
      as_d     = as_q;
      ds_d     = ds_q;
      rw_d     = rw_q;
      siz_d    = siz_q;
      a1_d     = a1_q;
      pop_d    = 1'b0;
      push_d   = 1'b0;
      inc_d    = 1'b0;
      buserr_d = buserr_q;
      case (state_q)
         S_IDLE: begin
            if (buserr_q) begin
               if (!DMAENA) buserr_d = 1'b0;
            end else if (start_ok) begin
               state_d = S_REQ;
               br_d    = 1'b0;
            end
         end
         S_REQ: begin
            if (!BG_) state_d = S_ARB;
         end
         S_ARB: begin
            if (AS_IN_ && BGACK_IN_) begin
               state_d = S_START;
               bgack_d = 1'b0;
               br_d    = 1'b1;
               as_d    = 1'b0;
               ds_d    = 1'b0;
               rw_d    = ~DMADIR;
               siz_d   = 2'b00;
               a1_d    = 1'b0;
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (bus_fail) begin
               state_d  = S_ERR;
               as_d     = 1'b1;
               ds_d     = 1'b1;
               bgack_d  = 1'b1;
               br_d     = 1'b1;
               buserr_d = 1'b1;
               half_d   = 1'b0;
            end else if (word_done) begin
               state_d = S_TERM;
               as_d    = 1'b1;
               ds_d    = 1'b1;
               pop_d   = DMADIR;
               push_d  = ~DMADIR;
               inc_d   = 1'b1;
               half_d  = 1'b0;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
            end else if (half_done) begin
               state_d = S_TERM;
               as_d    = 1'b1;
               ds_d    = 1'b1;
               half_d  = 1'b1;
            end
         end
         S_TERM: begin
            // Upper half of a longword on a 16-bit port goes straight back out.
            if (half_q) begin
               state_d = S_START;
               as_d    = 1'b0;
               ds_d    = 1'b0;
               siz_d   = 2'b10;
               a1_d    = 1'b1;
               half_d  = 1'b0;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (stop_burst) begin
               state_d = S_REL;
               bgack_d = 1'b1;
            end else begin
               state_d = S_START;
               as_d    = 1'b0;
               ds_d    = 1'b0;
               rw_d    = ~DMADIR;
               siz_d   = 2'b00;
               a1_d    = 1'b0;
            end
         end
         S_REL: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rw_d    = 1'b1;
            siz_d   = 2'b00;
            a1_d    = 1'b0;
         end
         S_ERR: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rw_d    = 1'b1;
            siz_d   = 2'b00;
            a1_d    = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge SCLK) begin
      if (!_RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         half_q   <= 1'b0;
         br_q     <= 1'b1;
         bgack_q  <= 1'b1;
         as_q     <= 1'b1;
         ds_q     <= 1'b1;
         rw_q     <= 1'b1;
         siz_q    <= 2'b00;
         a1_q     <= 1'b0;
         pop_q    <= 1'b0;
         push_q   <= 1'b0;
         inc_q    <= 1'b0;
         buserr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         br_q     <= br_d;
         bgack_q  <= bgack_d;
         as_q     <= as_d;
         ds_q     <= ds_d;
         rw_q     <= rw_d;
         siz_q    <= siz_d;
         a1_q     <= a1_d;
         pop_q    <= pop_d;
         push_q   <= push_d;
         inc_q    <= inc_d;
         buserr_q <= buserr_d;
      end
   end

   assign BR_       = br_q;
   assign BGACK_    = bgack_q;
   assign AS_       = as_q;
   assign DS_       = ds_q;
   assign RW        = rw_q;
   assign SIZ       = siz_q;
   assign A1        = a1_q;
   assign FIFO_POP  = pop_q;
   assign FIFO_PUSH = push_q;
   assign INCADR    = inc_q;
   assign BUSERR    = buserr_q;
   assign STATE     = state_q;

endmodule

// File: tb/tb_cpu_dma_master.sv
// tb/tb_cpu_dma_master.sv - bench for cpu_dma_master with FIFO, arbiter and bus-slave models
// Tenure expectations come from FIFO level and burst length arithmetic.
module tb_cpu_dma_master;

   localparam int BL    = 4;
   localparam int DEPTH = 8;

   logic       SCLK = 1'b0;
   logic       _RST;
   logic       DMAENA, DMADIR, FLUSHFIFO;
   logic [3:0] FIFO_LEVEL;
   logic       BG_, AS_IN_, BGACK_IN_, DSACK0_, DSACK1_, STERM_, BERR_;
   logic       BR_, BGACK_, AS_, DS_, RW, A1, FIFO_POP, FIFO_PUSH, INCADR, BUSERR;
   logic [1:0] SIZ;
   logic [3:0] STATE;

   cpu_dma_master #(.BURST_LEN(BL), .LVL_W(4), .FIFO_DEPTH(DEPTH)) dut (
      .SCLK(SCLK), ._RST(_RST), .DMAENA(DMAENA), .DMADIR(DMADIR),
      .FIFO_LEVEL(FIFO_LEVEL), .FLUSHFIFO(FLUSHFIFO), .BG_(BG_),
      .AS_IN_(AS_IN_), .BGACK_IN_(BGACK_IN_), .DSACK0_(DSACK0_), .DSACK1_(DSACK1_),
      .STERM_(STERM_), .BERR_(BERR_), .BR_(BR_), .BGACK_(BGACK_), .AS_(AS_),
      .DS_(DS_), .RW(RW), .SIZ(SIZ), .A1(A1), .FIFO_POP(FIFO_POP),
      .FIFO_PUSH(FIFO_PUSH), .INCADR(INCADR), .BUSERR(BUSERR), .STATE(STATE)
   );

   always #5 SCLK = ~SCLK;

   int   n_vec = 0, n_bad = 0;
   int   level = 0;
   int   term_kind = 0;   // 0 STERM, 1 DSACK 32-bit, 2 DSACK 16-bit, 3 BERR, 4 DSACK 8-bit
   int   wait_cyc = 0, as_low = 0, bg_delay = 0, br_low = 0, busy_left = 0;
   int   pops = 0, pushes = 0, incs = 0, as_pulses = 0;
   logic half = 1'b0, as_prev = 1'b1, asin_drv = 1'b1;

   assign FIFO_LEVEL = 4'(level);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {BR_, BGACK_, AS_, DS_, RW, SIZ, A1, FIFO_POP, FIFO_PUSH, INCADR, BUSERR, STATE};
   endfunction

   // One clock: observe at the falling edge, update models, drive next inputs.
   task automatic tick();
      @(negedge SCLK);
      if (FIFO_POP)  begin level--; pops++;   end
      if (FIFO_PUSH) begin level++; pushes++; end
      if (INCADR) incs++;
      if (!asin_drv) chk("arb_hold", BGACK_, 1'b1);
      if (!AS_ && as_prev) begin
         as_pulses++;
         chk("rw", RW, !DMADIR);
         chk("a1_siz", {A1, SIZ}, half ? 3'b110 : 3'b000);
         if (term_kind == 2) half = !half;
      end
      as_prev = AS_;
      STERM_ = 1'b1; DSACK0_ = 1'b1; DSACK1_ = 1'b1; BERR_ = 1'b1;
      if (!AS_) begin
         as_low++;
         if (as_low > wait_cyc) begin
            case (term_kind)
               0: STERM_ = 1'b0;
               1: begin DSACK0_ = 1'b0; DSACK1_ = 1'b0; end
               2: DSACK1_ = 1'b0;
               3: BERR_ = 1'b0;
               default: DSACK0_ = 1'b0;
            endcase
         end
      end else begin
         as_low   = 0;
         wait_cyc = $urandom_range(0, 2);
      end
      if (!BR_) begin
         br_low++;
         BG_ = (br_low > bg_delay) ? 1'b0 : 1'b1;
      end else begin
         br_low = 0;
         BG_    = 1'b1;
      end
      if (!BG_ && busy_left > 0) begin
         AS_IN_ = 1'b0;
         busy_left--;
      end else begin
         AS_IN_ = 1'b1;
      end
      asin_drv = AS_IN_;
   endtask

   task automatic run_tenure(input int dir, input int lvl, input int flush, input int kind,
                             input int bgd, input int busy, input int keep);
      int n, t;
      DMADIR = dir[0]; FLUSHFIFO = flush[0]; level = lvl; term_kind = kind;
      bg_delay = bgd; busy_left = busy; half = 1'b0;
      pops = 0; pushes = 0; incs = 0; as_pulses = 0;
      if (dir != 0) n = (lvl < BL) ? lvl : BL;
      else          n = ((DEPTH - lvl) < BL) ? (DEPTH - lvl) : BL;
      DMAENA = 1'b1;
      t = 0;
      while (BGACK_ && t < 40) begin tick(); t++; end
      chk("grant", BGACK_, 1'b0);
      t = 0;
      while (!BGACK_ && t < 200) begin tick(); t++; end
      if (keep == 0) DMAENA = 1'b0;
      chk("release", BGACK_, 1'b1);
      chk("pops", pops, (dir != 0) ? n : 0);
      chk("pushes", pushes, (dir != 0) ? 0 : n);
      chk("incadr", incs, n);
      chk("as_pulses", as_pulses, (kind == 2) ? 2 * n : n);
      chk("level_end", level, (dir != 0) ? lvl - n : lvl + n);
      if (keep == 0) begin
         repeat (3) tick();
         chk("idle_state", STATE, 4'd0);
         chk("idle_br", BR_, 1'b1);
      end
   endtask

   task automatic no_tenure(input int dir, input int lvl, input int flush);
      int brl;
      brl = 0;
      DMADIR = dir[0]; level = lvl; FLUSHFIFO = flush[0]; DMAENA = 1'b1;
      repeat (8) begin tick(); if (!BR_) brl++; end
      DMAENA = 1'b0; FLUSHFIFO = 1'b0;
      chk("no_tenure", brl, 0);
      repeat (2) tick();
   endtask

   task automatic run_error(input int kind);
      int   t, brl;
      logic as_before;
      DMADIR = 1'b1; level = 4; FLUSHFIFO = 1'b0; term_kind = kind;
      bg_delay = 0; busy_left = 0; half = 1'b0; DMAENA = 1'b1;
      as_before = 1'b1;
      t = 0;
      while (!BUSERR && t < 60) begin as_before = AS_; tick(); t++; end
      chk("err_flag", BUSERR, 1'b1);
      chk("err_as_was_low", as_before, 1'b0);
      chk("err_as", AS_, 1'b1);
      chk("err_ds", DS_, 1'b1);
      chk("err_bgack", BGACK_, 1'b1);
      chk("err_br", BR_, 1'b1);
      brl = 0;
      repeat (8) begin tick(); if (!BR_) brl++; end
      chk("err_no_br", brl, 0);
      chk("err_sticky", BUSERR, 1'b1);
      DMAENA = 1'b0;
      repeat (2) tick();
      chk("err_clear", BUSERR, 1'b0);
      term_kind = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      _RST = 1'b0; DMAENA = 1'b0; DMADIR = 1'b0; FLUSHFIFO = 1'b0;
      BG_ = 1'b1; AS_IN_ = 1'b1; BGACK_IN_ = 1'b1;
      DSACK0_ = 1'b1; DSACK1_ = 1'b1; STERM_ = 1'b1; BERR_ = 1'b1;
      repeat (3) tick();
      chk("reset", outs(), 16'hF800);
      _RST = 1'b1;
      repeat (2) tick();

      run_tenure(1, 4, 0, 0, 0, 0, 0);     // write burst, STERM_
      run_tenure(0, 0, 0, 2, 1, 0, 0);     // 16-bit port read
      run_tenure(1, 2, 1, 1, 0, 0, 0);     // flush two longwords
      run_tenure(1, 4, 0, 0, 0, 3, 0);     // other master holds AS_IN_ for 3 cycles

      no_tenure(1, 0, 1);
      no_tenure(1, 3, 0);
      no_tenure(0, 5, 0);

      // Back-to-back tenures: IDLE must separate REL from the next request.
      run_tenure(1, 8, 0, 1, 0, 0, 1);
      tick();
      chk("idle_gap", BR_, 1'b1);
      tick();
      chk("rerequest", BR_, 1'b0);
      run_tenure(1, 4, 0, 0, 0, 0, 0);

      run_error(3);
      run_error(4);

      // DMAENA drops during a split 16-bit longword: that longword still completes.
      DMADIR = 1'b1; level = 8; term_kind = 2; half = 1'b0; bg_delay = 0; busy_left = 0;
      pops = 0; incs = 0; as_pulses = 0; DMAENA = 1'b1;
      t = 0;
      while (AS_ && t < 40) begin tick(); t++; end
      DMAENA = 1'b0;
      t = 0;
      while (BGACK_ == 1'b0 && t < 60) begin tick(); t++; end
      chk("dis_release", BGACK_, 1'b1);
      chk("dis_pops", pops, 1);
      chk("dis_incadr", incs, 1);
      chk("dis_as_pulses", as_pulses, 2);
      repeat (3) tick();

      for (int i = 0; i < 14; i++) begin
         int dir, lvl, kind, fl;
         dir  = $urandom_range(0, 1);
         kind = $urandom_range(0, 2);
         lvl  = (dir != 0) ? $urandom_range(1, 8) : $urandom_range(0, 4);
         fl   = (dir != 0 && lvl < BL) ? 1 : $urandom_range(0, 1);
         run_tenure(dir, lvl, fl, kind, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      // Reset in the middle of a burst releases the bus on the next edge.
      DMADIR = 1'b1; level = 8; term_kind = 0; half = 1'b0; bg_delay = 0; busy_left = 0;
      DMAENA = 1'b1;
      t = 0;
      while (AS_ && t < 40) begin tick(); t++; end
      tick();
      _RST = 1'b0;
      tick();
      chk("reset_mid", outs(), 16'hF800);
      _RST = 1'b1; DMAENA = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
